// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider for DIV/DIVU in the execute stage.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle instead of 33.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  alucontrolE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        annulE,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o,
    output logic        result_valid,
    output logic        div_stall
);
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state, w_stateNext;
    logic [31:0] r_rem, r_quo, r_divisor, r_lo, r_hi;
    logic [4:0]  r_count;
    logic        r_quoNeg, r_remNeg;

    logic        w_isDiv, w_request, w_accept, w_divZero, w_fastZero;
    logic        w_signA, w_signB, w_keep, w_lastIter;
    logic [31:0] w_absA, w_absB, w_remNext, w_quoNext;
    logic [32:0] w_shift, w_trial;

    assign w_isDiv   = (alucontrolE == EXE_DIV_OP);
    assign w_request = w_isDiv || (alucontrolE == EXE_DIVU_OP);
    assign w_accept  = (r_state == IDLE) && w_request && !annulE;
    assign w_signA   = w_isDiv & srcaE[31];
    assign w_signB   = w_isDiv & srcbE[31];
    assign w_absA    = w_signA ? (32'd0 - srcaE) : srcaE;
    assign w_absB    = w_signB ? (32'd0 - srcbE) : srcbE;
    assign w_divZero = (srcbE == 32'd0);
`ifdef DIV_ZERO_FAST_EN
    assign w_fastZero = w_divZero;
`else
    assign w_fastZero = 1'b0;
`endif

    // Shifted value exceeds 32 bits only when the divisor is above 2^31, so the subtract then always succeeds.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_trial    = w_shift - {1'b0, r_divisor};
    assign w_keep     = w_shift[32] | ~w_trial[32];
    assign w_remNext  = w_keep ? w_trial[31:0] : w_shift[31:0];
    assign w_quoNext  = {r_quo[30:0], w_keep};
    assign w_lastIter = (r_state == BUSY) && !annulE && (r_count == 5'd31);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        result_valid = 1'b0;
        div_stall    = 1'b0;
        unique case (r_state)
            IDLE: begin
                div_stall = w_accept;
                if (w_accept) begin
                    w_stateNext = w_fastZero ? DONE : BUSY;
                end
            end
            BUSY: begin
                div_stall = 1'b1;
                if (annulE) begin
                    w_stateNext = IDLE;
                end else if (r_count == 5'd31) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                result_valid = !annulE;
                w_stateNext  = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // A zero divisor leaves rem=|a| and quo=all ones; negating rem by sign_a restores the raw dividend.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_quoNeg  <= 1'b0;
            r_remNeg  <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
        end else begin
            if (w_accept) begin
                r_rem     <= '0;
                r_quo     <= w_absA;
                r_divisor <= w_absB;
                r_count   <= '0;
                r_quoNeg  <= (w_signA ^ w_signB) & ~w_divZero;
                r_remNeg  <= w_signA;
                if (w_fastZero) begin
                    r_lo <= 32'hFFFF_FFFF;
                    r_hi <= srcaE;
                end
            end else if (r_state == BUSY) begin
                r_rem   <= w_remNext;
                r_quo   <= w_quoNext;
                r_count <= r_count + 5'd1;
            end
            if (w_lastIter) begin
                r_lo <= r_quoNeg ? (32'd0 - w_quoNext) : w_quoNext;
                r_hi <= r_remNeg ? (32'd0 - w_remNext) : w_remNext;
            end
        end
    end

    assign lo_o = r_lo;
    assign hi_o = r_hi;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an arithmetic reference model.
// Models a stalling pipeline: the request is re-presented while div_stall is high.
module tb_div_unit;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] NOP_OP      = 8'h00;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    logic        clk;
    logic        resetn;
    logic [7:0]  alucontrolE;
    logic [31:0] srcaE, srcbE;
    logic        annulE;
    logic [31:0] lo_o, hi_o;
    logic        result_valid, div_stall;

    int          testsRun;
    int          testsFailed;
    logic [31:0] lastQ, lastR;

    div_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .alucontrolE  (alucontrolE),
        .srcaE        (srcaE),
        .srcbE        (srcbE),
        .annulE       (annulE),
        .lo_o         (lo_o),
        .hi_o         (hi_o),
        .result_valid (result_valid),
        .div_stall    (div_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating division, dividend-signed remainder, MIPS-style divide-by-zero.
    function automatic void refDiv(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (op == EXE_DIVU_OP) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one divide for a fixed 37-cycle window; the instruction advances once stall drops.
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int firstValid, output int validCnt, output int stallCnt,
                                 output logic [31:0] q, output logic [31:0] r);
        logic stalled;
        firstValid = -1;
        validCnt   = 0;
        stallCnt   = 0;
        q          = '0;
        r          = '0;
        @(posedge clk);
        #1;
        alucontrolE = op;
        srcaE       = a;
        srcbE       = b;
        annulE      = 1'b0;
        for (int cyc = 0; cyc < 37; cyc++) begin
            @(negedge clk);
            if (div_stall) stallCnt++;
            if (result_valid) begin
                validCnt++;
                if (firstValid < 0) begin
                    firstValid = cyc;
                    q = lo_o;
                    r = hi_o;
                end
            end
            stalled = div_stall;
            @(posedge clk);
            #1;
            if (!stalled) begin
                alucontrolE = NOP_OP;
                srcaE       = $urandom;
                srcbE       = $urandom;
            end
        end
    endtask

    task automatic runCheck(input string tag, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] expQ, input logic [31:0] expR,
                            input int expLat);
        int firstValid, validCnt, stallCnt;
        logic [31:0] q, r;
        applyStimulus(op, a, b, firstValid, validCnt, stallCnt, q, r);
        checkOutput({tag, ".lo"}, q, expQ);
        checkOutput({tag, ".hi"}, r, expR);
        checkOutput({tag, ".latency"}, 32'(firstValid), 32'(expLat));
        checkOutput({tag, ".validPulses"}, 32'(validCnt), 32'd1);
        checkOutput({tag, ".stallCycles"}, 32'(stallCnt), 32'(expLat));
        lastQ = expQ;
        lastR = expR;
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] a, b, q, r;
        int          firstValid, validCnt;
        logic        stalledPrev, held;

        testsRun    = 0;
        testsFailed = 0;
        resetn      = 1'b0;
        alucontrolE = NOP_OP;
        srcaE       = '0;
        srcbE       = '0;
        annulE      = 1'b0;
        lastQ       = '0;
        lastR       = '0;

        #3;
        checkOutput("reset.lo", lo_o, 32'd0);
        checkOutput("reset.hi", hi_o, 32'd0);
        checkOutput("reset.valid", 32'(result_valid), 32'd0);
        checkOutput("reset.stall", 32'(div_stall), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        runCheck("divu100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        runCheck("divNeg7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        runCheck("div7_neg2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        runCheck("divMinNeg1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        runCheck("divuMax_1", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        runCheck("divu5_0", EXE_DIVU_OP, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZERO_LAT);
        runCheck("divNeg5_0", EXE_DIV_OP, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, ZERO_LAT);

        // Annul mid-division, then a fresh DIVU 9/4 accepted two cycles later.
        firstValid  = -1;
        validCnt    = 0;
        stalledPrev = 1'b1;
        held        = 1'b1;
        q           = '0;
        r           = '0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) begin
                alucontrolE = EXE_DIVU_OP;
                srcaE       = 32'd1000;
                srcbE       = 32'd3;
                annulE      = 1'b0;
            end else if (cyc == 10) begin
                annulE = 1'b1;
            end else if (cyc == 11) begin
                annulE      = 1'b0;
                alucontrolE = NOP_OP;
            end else if (cyc == 12) begin
                alucontrolE = EXE_DIVU_OP;
                srcaE       = 32'd9;
                srcbE       = 32'd4;
            end else if (cyc > 12 && !stalledPrev) begin
                alucontrolE = NOP_OP;
            end
            @(negedge clk);
            stalledPrev = div_stall;
            if (cyc == 11) checkOutput("annul.stallLow", 32'(div_stall), 32'd0);
            if (result_valid) begin
                validCnt++;
                if (firstValid < 0) begin
                    firstValid = cyc;
                    q = lo_o;
                    r = hi_o;
                end
            end
            if (cyc >= 1 && cyc <= 44 && (lo_o !== lastQ || hi_o !== lastR)) held = 1'b0;
        end
        checkOutput("annul.hiLoHeld", 32'(held), 32'd1);
        checkOutput("annul.nextLatency", 32'(firstValid), 32'd45);
        checkOutput("annul.validPulses", 32'(validCnt), 32'd1);
        checkOutput("annul.nextLo", q, 32'd2);
        checkOutput("annul.nextHi", r, 32'd1);

        // Asynchronous reset in the middle of a division.
        @(posedge clk);
        #1;
        alucontrolE = EXE_DIVU_OP;
        srcaE       = 32'd1000;
        srcbE       = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        resetn      = 1'b0;
        alucontrolE = NOP_OP;
        #2;
        checkOutput("midReset.lo", lo_o, 32'd0);
        checkOutput("midReset.hi", hi_o, 32'd0);
        checkOutput("midReset.valid", 32'(result_valid), 32'd0);
        checkOutput("midReset.stall", 32'(div_stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        runCheck("afterReset.divNeg9_4", EXE_DIV_OP, 32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);

        for (int i = 0; i < 20; i++) begin
            op = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                1: begin
                    b = $urandom_range(1, 15);
                    if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
                end
                2: b = 32'd0;
                3: begin
                    a = 32'h8000_0000;
                    if ($urandom_range(0, 1) == 1) b = 32'hFFFF_FFFF;
                end
                4: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            refDiv(op, a, b, q, r);
            runCheck($sformatf("rand%0d", i), op, a, b, q, r, (b == 32'd0) ? ZERO_LAT : 33);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
